// File: rtl/ps2_mouse_host.sv
// PS/2 mouse host: sends "enable data reporting" (0xF4), waits for 0xFA, then decodes
// 3-byte movement packets. Both PS/2 lines are open-collector and driven only via output enables.
module ps2_mouse_host #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned INHIBIT_US = 120,
   parameter int unsigned TIMEOUT_US = 2000
) (
   input  logic       iclk,
   input  logic       ireset,
   input  logic       ps2_clk_i,
   input  logic       ps2_data_i,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic [0:5] mouse,
   output logic [8:0] dx,
   output logic [8:0] dy,
   output logic       paquete_valido,
   output logic       listo,
   output logic       error
);
   localparam int unsigned INHIBIT_CYC = CLK_HZ / 1_000_000 * INHIBIT_US;
   localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int unsigned IW          = $clog2(INHIBIT_CYC + 1);
   localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0]  CMD         = 8'hF4;
   localparam logic [7:0]  ACK_BYTE    = 8'hFA;
   localparam logic        CMD_PARITY  = ~^CMD;

   typedef enum logic [2:0] {
      S_INHIBIT,
      S_REQ,
      S_TX,
      S_TX_ACK,
      S_WAIT_FA,
      S_STREAM
   } state_t;

   state_t        r_state;
   logic          r_clk_meta, r_clk_sync, r_clk_prev;
   logic          r_data_meta, r_data_sync;
   logic [IW-1:0] r_inh_cnt;
   logic [TW-1:0] r_to_cnt;
   logic [3:0]    r_bit_cnt;
   logic [9:0]    r_shift;
   logic [1:0]    r_idx;
   logic [5:0]    r_byte1;
   logic [7:0]    r_byte2;
   logic          r_clk_oe, r_data_oe, r_valid, r_listo, r_error;
   logic [0:5]    r_mouse;
   logic [8:0]    r_dx, r_dy;

   logic          w_fe, w_busy, w_timeout, w_frame_ok;
   logic [10:0]   w_frame;
   logic [7:0]    w_byte;

   always_ff @(posedge iclk) begin
      if (ireset) begin
         r_clk_meta  <= 1'b1;
         r_clk_sync  <= 1'b1;
         r_clk_prev  <= 1'b1;
         r_data_meta <= 1'b1;
         r_data_sync <= 1'b1;
      end else begin
         r_clk_meta  <= ps2_clk_i;
         r_clk_sync  <= r_clk_meta;
         r_clk_prev  <= r_clk_sync;
         r_data_meta <= ps2_data_i;
         r_data_sync <= r_data_meta;
      end
   end

   assign w_fe       = r_clk_prev & ~r_clk_sync;
   // Frame as it stands at the 11th edge: ten shifted bits plus the stop bit being sampled now.
   assign w_frame    = {r_data_sync, r_shift};
   assign w_byte     = w_frame[8:1];
   assign w_frame_ok = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);
   assign w_busy     = (r_bit_cnt != 4'd0) || (r_state inside {S_TX, S_TX_ACK, S_WAIT_FA});
   assign w_timeout  = w_busy & ~w_fe & (r_to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge iclk) begin
      if (ireset) begin
         r_shift  <= '0;
         r_to_cnt <= '0;
      end else begin
         if (w_fe) r_shift <= {r_data_sync, r_shift[9:1]};
         if (!w_busy || w_fe || w_timeout) r_to_cnt <= '0;
         else                              r_to_cnt <= r_to_cnt + TW'(1);
      end
   end

   always_ff @(posedge iclk) begin
      if (ireset) begin
         r_state   <= S_INHIBIT;
         r_inh_cnt <= '0;
         r_bit_cnt <= '0;
         r_idx     <= '0;
         r_byte1   <= '0;
         r_byte2   <= '0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_valid   <= 1'b0;
         r_listo   <= 1'b0;
         r_error   <= 1'b0;
         r_mouse   <= '0;
         r_dx      <= '0;
         r_dy      <= '0;
      end else begin
         r_valid <= 1'b0;
         r_error <= 1'b0;
         unique case (r_state)
            S_INHIBIT: begin
               r_clk_oe  <= 1'b1;
               r_data_oe <= 1'b0;
               r_bit_cnt <= '0;
               if (r_inh_cnt == IW'(INHIBIT_CYC - 1)) begin
                  r_inh_cnt <= '0;
                  r_state   <= S_REQ;
               end else begin
                  r_inh_cnt <= r_inh_cnt + IW'(1);
               end
            end
            S_REQ: begin
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b1;
               r_state   <= S_TX;
            end
            S_TX: begin
               if (w_timeout) begin
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b0;
                  r_bit_cnt <= '0;
                  r_state   <= S_INHIBIT;
               end else if (w_fe) begin
                  r_bit_cnt <= r_bit_cnt + 4'd1;
                  if (r_bit_cnt < 4'd8) begin
                     r_data_oe <= ~CMD[r_bit_cnt[2:0]];
                  end else if (r_bit_cnt == 4'd8) begin
                     r_data_oe <= ~CMD_PARITY;
                  end else begin
                     r_data_oe <= 1'b0;
                     r_bit_cnt <= '0;
                     r_state   <= S_TX_ACK;
                  end
               end
            end
            S_TX_ACK: begin
               if (w_timeout) begin
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b0;
                  r_state   <= S_INHIBIT;
               end else if (w_fe) begin
                  r_state <= r_data_sync ? S_INHIBIT : S_WAIT_FA;
               end
            end
            S_WAIT_FA: begin
               if (w_timeout) begin
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b0;
                  r_bit_cnt <= '0;
                  r_state   <= S_INHIBIT;
               end else if (w_fe) begin
                  if (r_bit_cnt == 4'd10) begin
                     r_bit_cnt <= '0;
                     if (w_frame_ok && (w_byte == ACK_BYTE)) begin
                        r_listo <= 1'b1;
                        r_idx   <= '0;
                        r_state <= S_STREAM;
                     end else begin
                        r_error <= 1'b1;
                        r_state <= S_INHIBIT;
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
            end
            S_STREAM: begin
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               if (w_timeout) begin
                  r_bit_cnt <= '0;
                  r_idx     <= '0;
                  r_error   <= 1'b1;
               end else if (w_fe) begin
                  if (r_bit_cnt == 4'd10) begin
                     r_bit_cnt <= '0;
                     if (!w_frame_ok) begin
                        r_error <= 1'b1;
                        r_idx   <= '0;
                     end else begin
                        case (r_idx)
                           2'd0: begin
                              // Bit 3 of the first byte is always set; otherwise we are out of step.
                              if (w_byte[3]) begin
                                 r_byte1 <= w_byte[5:0];
                                 r_idx   <= 2'd1;
                              end else begin
                                 r_error <= 1'b1;
                              end
                           end
                           2'd1: begin
                              r_byte2 <= w_byte;
                              r_idx   <= 2'd2;
                           end
                           default: begin
                              for (int i = 0; i < 6; i++) r_mouse[i] <= r_byte1[i];
                              r_dx    <= {r_byte1[4], r_byte2};
                              r_dy    <= {r_byte1[5], w_byte};
                              r_valid <= 1'b1;
                              r_idx   <= 2'd0;
                           end
                        endcase
                     end
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
               end
            end
            default: begin
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               r_bit_cnt <= '0;
               r_state   <= S_INHIBIT;
            end
         endcase
      end
   end

   assign ps2_clk_oe     = r_clk_oe;
   assign ps2_data_oe    = r_data_oe;
   assign mouse          = r_mouse;
   assign dx             = r_dx;
   assign dy             = r_dy;
   assign paquete_valido = r_valid;
   assign listo          = r_listo;
   assign error          = r_error;

endmodule

// File: tb/tb_ps2_mouse_host.sv
// Bench for ps2_mouse_host: a PS/2 device model drives the lines, a packet-level reference
// model fills a scoreboard queue, and a monitor pops and compares on every paquete_valido.
module tb_ps2_mouse_host;
   localparam int unsigned CLK_HZ     = 1_000_000;
   localparam int unsigned INHIBIT_US = 120;
   localparam int unsigned TIMEOUT_US = 2000;
   localparam int          INH_CYC    = CLK_HZ / 1_000_000 * INHIBIT_US;
   localparam int          TO_CYC     = CLK_HZ / 1_000_000 * TIMEOUT_US;
   localparam int          HALF       = 10;

   logic       iclk     = 1'b0;
   logic       ireset   = 1'b1;
   logic       dev_clk  = 1'b1;
   logic       dev_data = 1'b1;
   logic       clk_line, data_line;
   logic       ps2_clk_oe, ps2_data_oe, paquete_valido, listo, error;
   logic [0:5] mouse;
   logic [8:0] dx, dy;

   assign clk_line  = ~ps2_clk_oe & dev_clk;
   assign data_line = ~ps2_data_oe & dev_data;

   ps2_mouse_host #(
      .CLK_HZ    (CLK_HZ),
      .INHIBIT_US(INHIBIT_US),
      .TIMEOUT_US(TIMEOUT_US)
   ) dut (
      .iclk          (iclk),
      .ireset        (ireset),
      .ps2_clk_i     (clk_line),
      .ps2_data_i    (data_line),
      .ps2_clk_oe    (ps2_clk_oe),
      .ps2_data_oe   (ps2_data_oe),
      .mouse         (mouse),
      .dx            (dx),
      .dy            (dy),
      .paquete_valido(paquete_valido),
      .listo         (listo),
      .error         (error)
   );

   always #5 iclk = ~iclk;

   typedef struct {
      logic [7:0] b1;
      int         dx;
      int         dy;
   } pkt_t;

   pkt_t       exp_q[$];
   int         n_tests  = 0;
   int         n_fail   = 0;
   int         err_seen = 0;
   int         err_exp  = 0;
   int         m_idx    = 0;
   logic [7:0] m_b1     = 8'h00;
   logic [7:0] m_b2     = 8'h00;
   int         last_dx  = 0;
   int         last_dy  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge iclk);
   endtask

   function automatic logic [5:0] mouse_bits();
      logic [5:0] m;
      for (int i = 0; i < 6; i++) m[i] = mouse[i];
      return m;
   endfunction

   function automatic int delta(input logic sign, input logic [7:0] mag);
      return sign ? int'(mag) - 256 : int'(mag);
   endfunction

   // kind: 0 clean frame, 1 parity error, 2 stop-bit error
   function automatic void model_byte(input logic [7:0] b, input int kind);
      if (kind != 0) begin
         err_exp++;
         m_idx = 0;
      end else if (m_idx == 0) begin
         if (b[3]) begin
            m_b1  = b;
            m_idx = 1;
         end else begin
            err_exp++;
         end
      end else if (m_idx == 1) begin
         m_b2  = b;
         m_idx = 2;
      end else begin
         pkt_t p;
         p.b1    = m_b1;
         p.dx    = delta(m_b1[4], m_b2);
         p.dy    = delta(m_b1[5], b);
         last_dx = p.dx;
         last_dy = p.dy;
         exp_q.push_back(p);
         m_idx   = 0;
      end
   endfunction

   task automatic dev_send(input logic [7:0] b, input int kind, input int nbits);
      logic [10:0] f;
      f = {(kind == 2) ? 1'b0 : 1'b1, (($countones(b) % 2) == 0) ^ (kind == 1), b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         dev_data = f[i];
         wait_cyc(5);
         dev_clk = 1'b0;
         wait_cyc(HALF);
         dev_clk = 1'b1;
         wait_cyc(5);
      end
      dev_data = 1'b1;
      wait_cyc(30);
   endtask

   task automatic send_byte(input logic [7:0] b, input int kind);
      model_byte(b, kind);
      dev_send(b, kind, 11);
   endtask

   task automatic wait_request(output bit seen);
      int t = 0;
      while (!(clk_line === 1'b1 && data_line === 1'b0) && t < 20000) begin
         wait_cyc(1);
         t++;
      end
      seen = (t < 20000);
      check("cmd_request_seen", 32'(seen), 1);
   endtask

   task automatic dev_recv_cmd(input bit ack);
      logic [10:0] rx;
      bit          seen;
      wait_request(seen);
      if (!seen) return;
      wait_cyc(10);
      rx[0] = data_line;
      for (int k = 1; k <= 10; k++) begin
         dev_clk = 1'b0;
         wait_cyc(HALF);
         dev_clk = 1'b1;
         rx[k]   = data_line;
         wait_cyc(HALF);
      end
      check("cmd_start", 32'(rx[0]), 0);
      check("cmd_byte", 32'(rx[8:1]), 32'h0000_00F4);
      check("cmd_parity", 32'(rx[9]), 32'(($countones(8'hF4) % 2) == 0));
      check("cmd_stop", 32'(rx[10]), 1);
      dev_data = ack ? 1'b0 : 1'b1;
      wait_cyc(5);
      dev_clk = 1'b0;
      wait_cyc(HALF);
      dev_clk = 1'b1;
      wait_cyc(5);
      dev_data = 1'b1;
      wait_cyc(20);
   endtask

   task automatic apply_reset();
      ireset = 1'b1;
      wait_cyc(2);
      check("rst_clk_oe", 32'(ps2_clk_oe), 0);
      check("rst_data_oe", 32'(ps2_data_oe), 0);
      check("rst_mouse", 32'(mouse_bits()), 0);
      check("rst_dx", 32'(dx), 0);
      check("rst_dy", 32'(dy), 0);
      check("rst_flags", 32'({paquete_valido, listo, error}), 0);
      m_idx   = 0;
      last_dx = 0;
      last_dy = 0;
      ireset  = 1'b0;
   endtask

   task automatic init_seq(input bit nack_first);
      int cnt = 0;
      fork
         begin
            @(negedge iclk);
            while (ps2_clk_oe === 1'b1 && cnt < 10 * INH_CYC) begin
               cnt++;
               @(negedge iclk);
            end
         end
         begin
            if (nack_first) dev_recv_cmd(1'b0);
            dev_recv_cmd(1'b1);
            dev_send(8'hFA, 0, 11);
         end
      join
      check("inhibit_cycles", 32'(cnt), 32'(INH_CYC));
      check("listo_after_fa", 32'(listo), 1);
   endtask

   task automatic checkpoint(input string name);
      wait_cyc(40);
      check({name, "_errors"}, 32'(err_seen), 32'(err_exp));
      check({name, "_pending"}, 32'(exp_q.size()), 0);
   endtask

   // Scoreboard monitor
   initial begin
      forever begin
         @(negedge iclk);
         if (ireset === 1'b0) begin
            if (error === 1'b1) err_seen++;
            if (paquete_valido === 1'b1) begin
               check("packet_expected", 32'(exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  pkt_t p;
                  int   gdx;
                  int   gdy;
                  p   = exp_q.pop_front();
                  gdx = $signed(dx);
                  gdy = $signed(dy);
                  check("pkt_mouse", 32'(mouse_bits()), 32'(p.b1[5:0]));
                  check("pkt_dx", gdx, p.dx);
                  check("pkt_dy", gdy, p.dy);
               end
            end
         end
      end
   end

   initial begin
      #(900_000);
      $display("FAIL watchdog: run did not complete, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int  gdx;
      int  gdy;
      bit  seen;

      // Bring-up with one NACK, so the command is retried.
      apply_reset();
      init_seq(1'b1);
      checkpoint("init");

      send_byte(8'h19, 0);
      send_byte(8'h05, 0);
      send_byte(8'hF0, 0);
      checkpoint("pkt1");
      check("pkt1_mouse_raw", 32'(mouse_bits()), 32'h19);
      check("pkt1_dx_raw", 32'(dx), 32'h105);
      check("pkt1_dy_raw", 32'(dy), 32'h0F0);

      send_byte(8'h1C, 0);
      send_byte(8'h55, 1);
      send_byte(8'h09, 0);
      send_byte(8'h01, 0);
      send_byte(8'h02, 0);
      checkpoint("parity");

      send_byte(8'h00, 0);
      send_byte(8'h08, 0);
      send_byte(8'h03, 0);
      send_byte(8'h04, 0);
      checkpoint("resync");

      // Clock stops mid-frame after five bits.
      dev_send(8'h18, 0, 5);
      wait_cyc(TO_CYC + 500);
      err_exp++;
      m_idx = 0;
      gdx   = $signed(dx);
      gdy   = $signed(dy);
      check("timeout_dx_hold", gdx, last_dx);
      check("timeout_dy_hold", gdy, last_dy);
      checkpoint("timeout");
      send_byte(8'h28, 0);
      send_byte(8'h10, 0);
      send_byte(8'hFE, 0);
      checkpoint("after_timeout");

      for (int it = 0; it < 60; it++) begin
         int         r;
         int         kind;
         logic [7:0] b;
         r    = $urandom_range(0, 9);
         b    = 8'($urandom);
         kind = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
         if (m_idx == 0 && r > 3) b[3] = 1'b1;
         send_byte(b, kind);
      end
      checkpoint("random");

      // Reset in the middle of the command transmission.
      apply_reset();
      wait_request(seen);
      wait_cyc(10);
      for (int k = 0; k < 4; k++) begin
         dev_clk = 1'b0;
         wait_cyc(HALF);
         dev_clk = 1'b1;
         wait_cyc(HALF);
      end
      ireset = 1'b1;
      wait_cyc(1);
      check("midtx_rst_clk_oe", 32'(ps2_clk_oe), 0);
      check("midtx_rst_data_oe", 32'(ps2_data_oe), 0);
      apply_reset();
      init_seq(1'b0);
      checkpoint("reinit");
      send_byte(8'h39, 0);
      send_byte(8'h80, 0);
      send_byte(8'h7F, 0);
      checkpoint("final");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ps2_mouse_host.md
# ps2_mouse_host

PS/2 host controller for the game's mouse input. After reset it sends the "enable data reporting" command (0xF4) to the mouse and checks for the 0xFA acknowledge. It then receives 3-byte movement packets and presents the button/sign status bits. Those bits feed the `mouse` input of the control selector, plus X/Y deltas and a packet strobe. The PS/2 lines are open-collector: this block only drives them low through output enables.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000: `iclk` frequency.
- `INHIBIT_US`, 120: host clock-inhibit time before a command, in µs.
- `TIMEOUT_US`, 2000: maximum gap between PS/2 clock falling edges inside a frame or handshake.

Ports:
- `iclk` in 1: system clock. This is the single clock domain.
- `ireset` in 1: reset, synchronous and active-high.
- `ps2_clk_i` in 1: PS/2 clock line, read back from the pad. Asynchronous.
- `ps2_data_i` in 1: PS/2 data line, read back from the pad. Asynchronous.
- `ps2_clk_oe` out 1: 1 pulls the PS/2 clock low; 0 releases it.
- `ps2_data_oe` out 1: 1 pulls the PS/2 data line low; 0 releases it.
- `mouse` out [0:5]: `mouse[i]` = bit i of packet byte 1. Bits 0/1/2 are left/right/middle, bit 3 is always 1, bits 4/5 are the X/Y sign.
- `dx` out [8:0]: {byte1 bit4, byte2}, two's complement.
- `dy` out [8:0]: {byte1 bit5, byte3}, two's complement.
- `paquete_valido` out 1: one-cycle pulse when `mouse`/`dx`/`dy` update.
- `listo` out 1: 1 once 0xFA has been received, i.e. the block is streaming.
- `error` out 1: one-cycle pulse on a parity, framing, timeout or resync discard.

## Operation
- Input conditioning: each PS/2 input passes through a 2-FF synchronizer. A falling edge ("fe") is a 1→0 transition of the synchronized clock.
- States: S_INHIBIT → S_REQ → S_TX → S_TX_ACK → S_WAIT_FA → S_STREAM.
- S_INHIBIT: `ps2_clk_oe`=1 for INHIBIT_CYC = CLK_HZ/1_000_000*INHIBIT_US cycles, then go to S_REQ.
- S_REQ: `ps2_data_oe`=1 (start bit); `ps2_clk_oe`=0 in the same cycle. Go to S_TX.
- S_TX: on fe k, for k=1..8, drive data bit k-1 of 0xF4, LSB first. Driving bit b means `ps2_data_oe`=~b.
  - fe 9: drive odd parity (0xF4 → parity 0, so `ps2_data_oe`=1).
  - fe 10: release data (stop bit). Go to S_TX_ACK.
- S_TX_ACK: on the next fe, sample data. 0 = ACK → go to S_WAIT_FA; 1 = no ACK → go to S_INHIBIT (retry).
- Receive frame, used in S_WAIT_FA and S_STREAM:
  - 11 bits, sampled on fe: start (must be 0), 8 data LSB first, parity, stop (must be 1).
  - A byte is accepted only if the start bit is 0, the stop bit is 1, and the parity is odd over data+parity.
- S_WAIT_FA:
  - Accepted byte == 0xFA: `listo`←1 and go to S_STREAM.
  - Any other accepted byte, or any frame error: pulse `error` and go to S_INHIBIT.
- S_STREAM: a byte index 0..2 tracks the packet.
  - Index 0: a byte with bit3=0 is discarded (`error` pulse, index stays 0). Otherwise store it and go to index 1.
  - Index 1: store byte 2 and go to index 2.
  - Index 2: all outputs update together, `paquete_valido` pulses, index returns to 0.
  - Any frame error: pulse `error`, drop the partial packet, index←0.
- Timeout: with a frame or handshake in progress (bit count ≠ 0, or state S_TX/S_TX_ACK/S_WAIT_FA), no fe for TIMEOUT_CYC cycles aborts.
  - S_TX, S_TX_ACK, S_WAIT_FA: release both lines and go to S_INHIBIT.
  - S_STREAM: clear the bit count, index←0, pulse `error`.
- S_WAIT_FA with no frame started for TIMEOUT_CYC also goes to S_INHIBIT. Retries are unbounded.
- In S_STREAM both output enables are 0 at all times.

## Timing
- Reset: state S_INHIBIT, inhibit counter 0.
  - All outputs: `ps2_data_oe`=0, `mouse`=6'b000000, `dx`=0, `dy`=0, `paquete_valido`=0, `listo`=0, `error`=0.
  - `ps2_clk_oe` becomes 1 in the first cycle after reset deasserts.
- Reset mid-operation: has the same effect at any point; both lines are released in the cycle where `ireset`=1.
- fe is detected 3 `iclk` cycles after the pad transition (2 synchronizer stages + edge register).
- Bit sampling and driving happen in the cycle fe is asserted. `ps2_data_oe` changes one cycle after fe.
- Stop bit to outputs:
  - `paquete_valido` and the updated `mouse`/`dx`/`dy` appear 1 cycle after the fe that samples the stop bit of byte 3.
  - Outputs then hold until the next valid packet.
- `listo` rises 1 cycle after the fe of the 0xFA stop bit. It stays 1 until reset, including across stream errors.
- Simultaneous events: a timeout and an fe in the same cycle count as an fe (no timeout).

## Test plan
- Init: reset 2 cycles, then release. Expect `ps2_clk_oe`=1 for exactly 6000 cycles (50 MHz, 120 µs). The device model clocks in 0xF4 with parity 0 and returns ACK, then sends frame 0xFA. Expect `listo`=1 and `error` never pulsed.
- Packet 0x19,0x05,0xF0 → `mouse`=[1,0,0,1,1,0], `dx`=9'h105 (−251), `dy`=9'h0F0 (+240), one `paquete_valido` pulse.
- Parity error on byte 2 → `error` pulse and no `paquete_valido`. A following clean packet 0x09,0x01,0x02 decodes to `dx`=1, `dy`=2.
- Resync: stream 0x00 (bit3=0) then 0x08,0x03,0x04. Expect one `error` pulse, then `dx`=3, `dy`=4.
- Timeout: stop the clock after 5 bits of byte 1 for >100000 cycles → `error` pulse, no output change. The next full packet decodes correctly.
- Retry: the device NACKs (data high at fe 11) → the block returns to S_INHIBIT and resends 0xF4. Assert `ireset` during S_TX → both oe=0 next cycle, and the init sequence restarts.
